// File: rtl/rc5_manchester_rx.sv
// RC-5 style Manchester receiver: locks on the MSB mid-bit edge, samples both
// half-bits of each following bit free-running from that edge, and strobes the code word.
module rc5_manchester_rx #(
    parameter int unsigned HALF_BIT = 32,
    parameter int unsigned NBITS    = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             din,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    localparam int unsigned      CNT_W     = $clog2(2 * NBITS * HALF_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_QTR   = CNT_W'(HALF_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(2 * HALF_BIT - 1);

    typedef enum logic [1:0] {
        GUARD,
        IDLE,
        CHECK,
        RECV
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, din_s_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             half_q, half_d;
    logic             a_q, a_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [NBITS-1:0] pos_q, pos_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             rise_c, done_c, viol_c;
    logic [NBITS-1:0] merged_c;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            din_s_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            din_s_q <= sync1_q;
            prev_q  <= din_s_q;
        end
    end

    assign rise_c   = din_s_q & ~prev_q;
    // pos_q is one-hot on the bit slot that the current B sample fills
    assign merged_c = shreg_q | (din_s_q ? pos_q : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            a_q     <= 1'b0;
            shreg_q <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            a_q     <= a_d;
            shreg_q <= shreg_d;
            pos_q   <= pos_d;
        end
    end

    // Next state; cnt_q counts cycles since the last sample point (or since t0)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        a_d     = a_q;
        shreg_d = shreg_q;
        pos_d   = pos_q;
        done_c  = 1'b0;
        viol_c  = 1'b0;
        case (state_q)
            GUARD: begin
                if (din_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_GUARD) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (rise_c) begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(1);
                    half_d  = 1'b0;
                    a_d     = 1'b0;
                    shreg_d = NBITS'(1) << (NBITS - 1);
                    pos_d   = NBITS'(1) << (NBITS - 2);
                end
            end
            CHECK: begin
                if (cnt_q == CNT_QTR) begin
                    state_d = din_s_q ? RECV : IDLE;
                    cnt_d   = din_s_q ? CNT_W'(1) : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECV: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_W'(1);
                    if (!half_q) begin
                        a_d    = din_s_q;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (a_q == din_s_q) begin
                            viol_c  = 1'b1;
                            state_d = GUARD;
                            cnt_d   = '0;
                        end else begin
                            shreg_d = merged_c;
                            pos_d   = pos_q >> 1;
                            if (pos_q[0]) begin
                                done_c  = 1'b1;
                                state_d = GUARD;
                                cnt_d   = '0;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values; everything leaves through registers
    always_comb begin
        valid_d = done_c;
        err_d   = viol_c;
        data_d  = done_c ? merged_c : data_q;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_rc5_manchester_rx.sv
// Bench for rc5_manchester_rx: waveform-level frame generator with expected
// code words and strobe times derived from the line coding and latency rules.
module tb_rc5_manchester_rx;

    localparam int unsigned H = 8;
    localparam int unsigned N = 11;
    localparam int LAT = 2 * (N - 1) * H + H / 2;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         din;
    logic [N-1:0] data;
    logic         valid;
    logic         err;
    logic         busy;

    int           cyc = 0;
    int           checks = 0;
    int           passed = 0;
    int           vq[$];
    logic [N-1:0] dq[$];
    int           eq[$];
    bit           both_seen = 1'b0;
    logic [N-1:0] model_data = '0;

    rc5_manchester_rx #(.HALF_BIT(H), .NBITS(N)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (din),
        .data   (data),
        .valid  (valid),
        .err    (err),
        .busy   (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe recorder, sampled on the falling edge
    always @(negedge clock) begin
        if (valid) begin
            vq.push_back(cyc);
            dq.push_back(data);
        end
        if (err) eq.push_back(cyc);
        if (valid && err) both_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic lvl, input int n);
        repeat (n) begin
            @(negedge clock);
            din = lvl;
        end
    endtask

    task automatic clear_q();
        vq.delete();
        dq.delete();
        eq.delete();
    endtask

    // Drives gap low cycles then up to nhalves half-bits of code; bit viol (MSB = 0)
    // is sent as vlev for both halves and ends the frame. k = cycle din first rose.
    task automatic send(input logic [N-1:0] code, input int viol, input logic vlev,
                        input int nhalves, input int gap, output int k);
        int           last;
        logic [N-1:0] sh;
        logic         lvl;
        k    = -1;
        last = (viol >= 0) ? 2 * (viol + 1) : 2 * N;
        if (nhalves < last) last = nhalves;
        drive(1'b0, gap);
        for (int h = 0; h < last; h++) begin
            sh  = code >> (N - 1 - h / 2);
            lvl = (h / 2 == viol) ? vlev : ((h % 2 == 0) ? ~sh[0] : sh[0]);
            for (int c = 0; c < H; c++) begin
                @(negedge clock);
                din = lvl;
                if (h == 1 && c == 0) k = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (data !== '0) $display("FAIL reset_data got %h want 000", data); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else passed++;
        reset_n = 1'b1;
        drive(1'b0, 2 * H - 2);
        checks++; if (busy !== 1'b1) $display("FAIL guard_busy got %b want 1", busy); else passed++;
        drive(1'b0, 4);
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_basic();
        int k;
        clear_q();
        send(11'h607, -1, 1'b0, 2 * N, 10, k);
        drive(1'b0, 4);
        model_data = 11'h607;
        checks++; if (vq.size() != 1) $display("FAIL basic_nvalid got %0d want 1", vq.size()); else passed++;
        checks++; if ((vq.size() > 0 ? vq[0] : -1) != k + 3 + LAT)
            $display("FAIL basic_latency got %0d want %0d", (vq.size() > 0 ? vq[0] : -1), k + 3 + LAT); else passed++;
        checks++; if (data !== model_data) $display("FAIL basic_data got %h want %h", data, model_data); else passed++;
        checks++; if (eq.size() != 0) $display("FAIL basic_err got %0d want 0", eq.size()); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy_guard got %b want 1", busy); else passed++;
        drive(1'b0, 2 * H + 4);
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        clear_q();
        send(11'h604, -1, 1'b0, 2 * N, 10, k1);
        send(11'h600, -1, 1'b0, 2 * N, 10, k2);
        drive(1'b0, 4);
        model_data = 11'h600;
        checks++; if (vq.size() != 2) $display("FAIL b2b_nvalid got %0d want 2", vq.size()); else passed++;
        checks++; if ((dq.size() > 0 ? dq[0] : 11'h0) !== 11'h604)
            $display("FAIL b2b_first got %h want 604", (dq.size() > 0 ? dq[0] : 11'h0)); else passed++;
        checks++; if ((dq.size() > 1 ? dq[1] : 11'h0) !== 11'h600)
            $display("FAIL b2b_second got %h want 600", (dq.size() > 1 ? dq[1] : 11'h0)); else passed++;
        checks++; if ((vq.size() > 1 ? vq[1] : -1) != k2 + 3 + LAT)
            $display("FAIL b2b_latency got %0d want %0d", (vq.size() > 1 ? vq[1] : -1), k2 + 3 + LAT); else passed++;
        checks++; if (eq.size() != 0) $display("FAIL b2b_err got %0d want 0", eq.size()); else passed++;
    endtask

    task automatic test_violation();
        int k;
        clear_q();
        send(11'h607, 5, 1'b1, 2 * N, 10, k);
        drive(1'b0, 4);
        checks++; if (eq.size() != 1) $display("FAIL viol_nerr got %0d want 1", eq.size()); else passed++;
        checks++; if ((eq.size() > 0 ? eq[0] : -1) != k + 3 + 2 * 5 * H + H / 2)
            $display("FAIL viol_time got %0d want %0d", (eq.size() > 0 ? eq[0] : -1), k + 3 + 2 * 5 * H + H / 2); else passed++;
        checks++; if (vq.size() != 0) $display("FAIL viol_valid got %0d want 0", vq.size()); else passed++;
        checks++; if (data !== model_data) $display("FAIL viol_data got %h want %h", data, model_data); else passed++;
        // Only 4 + 3 + H = 15 low cycles since the error: still guarding
        clear_q();
        send(11'h600, -1, 1'b0, 2 * N, 3, k);
        drive(1'b0, 4);
        checks++; if (vq.size() != 0) $display("FAIL viol_guard_valid got %0d want 0", vq.size()); else passed++;
        checks++; if (eq.size() != 0) $display("FAIL viol_guard_err got %0d want 0", eq.size()); else passed++;
    endtask

    task automatic test_glitch();
        int k, first, nbusy;
        drive(1'b0, 2 * H);
        clear_q();
        first = -1;
        nbusy = 0;
        @(negedge clock);
        din = 1'b1;
        k   = cyc;
        drive(1'b1, 1);
        for (int i = 0; i < 3 * H; i++) begin
            @(negedge clock);
            din = 1'b0;
            if (busy) begin
                nbusy++;
                if (first < 0) first = cyc;
            end
        end
        checks++; if (nbusy != H / 2) $display("FAIL glitch_busy_len got %0d want %0d", nbusy, H / 2); else passed++;
        checks++; if (first != k + 3) $display("FAIL glitch_busy_start got %0d want %0d", first, k + 3); else passed++;
        checks++; if (vq.size() + eq.size() != 0)
            $display("FAIL glitch_strobes got %0d want 0", vq.size() + eq.size()); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int k;
        clear_q();
        send(11'h607, -1, 1'b0, 9, 10, k);
        reset_n = 1'b0;
        #1;
        model_data = '0;
        checks++; if (data !== '0) $display("FAIL rstmid_data got %h want 000", data); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy got %b want 1", busy); else passed++;
        checks++; if (valid !== 1'b0 || err !== 1'b0)
            $display("FAIL rstmid_strobes got %b%b want 00", valid, err); else passed++;
        din = 1'b0;
        drive(1'b0, 2);
        reset_n = 1'b1;
        drive(1'b0, 2 * H + 2);
        checks++; if (vq.size() + eq.size() != 0)
            $display("FAIL rstmid_abandon got %0d want 0", vq.size() + eq.size()); else passed++;
        send(11'h604, -1, 1'b0, 2 * N, 4, k);
        drive(1'b0, 4);
        model_data = 11'h604;
        checks++; if (vq.size() != 1) $display("FAIL rstmid_nvalid got %0d want 1", vq.size()); else passed++;
        checks++; if (data !== model_data) $display("FAIL rstmid_next got %h want %h", data, model_data); else passed++;
    endtask

    task automatic test_guard_window();
        int k;
        clear_q();
        drive(1'b1, 50);
        send(11'h600, -1, 1'b0, 2 * N, 15 - H, k);
        drive(1'b0, 4);
        checks++; if (vq.size() + eq.size() != 0)
            $display("FAIL guard15_strobes got %0d want 0", vq.size() + eq.size()); else passed++;
        checks++; if (data !== model_data) $display("FAIL guard15_data got %h want %h", data, model_data); else passed++;
        drive(1'b1, 50);
        send(11'h600, -1, 1'b0, 2 * N, 16 - H, k);
        drive(1'b0, 4);
        model_data = 11'h600;
        checks++; if (vq.size() != 1) $display("FAIL guard16_nvalid got %0d want 1", vq.size()); else passed++;
        checks++; if ((vq.size() > 0 ? vq[0] : -1) != k + 3 + LAT)
            $display("FAIL guard16_latency got %0d want %0d", (vq.size() > 0 ? vq[0] : -1), k + 3 + LAT); else passed++;
        checks++; if (data !== model_data) $display("FAIL guard16_data got %h want %h", data, model_data); else passed++;
    endtask

    task automatic test_random();
        int           k, viol, gap, texp;
        logic         vlev;
        logic [N-1:0] code;
        for (int f = 0; f < 16; f++) begin
            code = N'($urandom) | (N'(1) << (N - 1));
            viol = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N - 1)) : -1;
            vlev = 1'($urandom_range(0, 1));
            gap  = int'($urandom_range(10, 30));
            clear_q();
            send(code, viol, vlev, 2 * N, gap, k);
            drive(1'b0, 4);
            if (viol < 0) begin
                model_data = code;
                texp = k + 3 + LAT;
                checks++; if ((vq.size() == 1 ? vq[0] : -1) != texp)
                    $display("FAIL rand_valid f%0d got %0d want %0d", f, (vq.size() == 1 ? vq[0] : -1), texp); else passed++;
                checks++; if (eq.size() != 0) $display("FAIL rand_err f%0d got %0d want 0", f, eq.size()); else passed++;
            end else begin
                texp = k + 3 + 2 * viol * H + H / 2;
                checks++; if ((eq.size() == 1 ? eq[0] : -1) != texp)
                    $display("FAIL rand_viol f%0d got %0d want %0d", f, (eq.size() == 1 ? eq[0] : -1), texp); else passed++;
                checks++; if (vq.size() != 0) $display("FAIL rand_novalid f%0d got %0d want 0", f, vq.size()); else passed++;
            end
            checks++; if (data !== model_data)
                $display("FAIL rand_data f%0d got %h want %h", f, data, model_data); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_violation();
        test_glitch();
        test_reset_mid_frame();
        test_guard_window();
        test_random();
        checks++; if (both_seen) $display("FAIL valid_err_overlap got 1 want 0"); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
